moda_sched: RTL and testbench
=============================

Name: moda_sched

Overview:
Sequential controller for the "moda" half-sum compare operation.
- Each accepted 32-bit g/e operand pair drives one shared N-bit adder twice (high halves, then low halves).
- The two (N+1)-bit sums are compared, and a 2-bit result code is returned over a valid/ready handshake.
- Keeps saturating tallies of outcomes for the surrounding garbled-circuit test harness.

Parameters:
N, 16, half-operand width; operands are 2N bits, sums are N+1 bits
CNT_W, 8, width of each outcome tally counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  operand pair offered
in_ready  out  1  controller can accept operands
g_input  in  2N  garbler operand
e_input  in  2N  evaluator operand
out_valid  out  1  result code valid
out_ready  in  1  consumer takes result
o  out  2  result code: 0 = hi-sum > lo-sum, 1 = hi-sum < lo-sum, 2 = equal
busy  out  1  FSM not in IDLE
cnt_clr  in  1  synchronous clear of all tallies
cnt_gt  out  CNT_W  count of code-0 results
cnt_lt  out  CNT_W  count of code-1 results
cnt_eq  out  CNT_W  count of code-2 results

Behaviour:
- Reset (rst low, asynchronous): state IDLE, in_ready=0 while rst asserted, out_valid=0, o=2'b11 (reserved, never produced otherwise), busy=0, sum registers=0, all counters=0. Reset mid-operation aborts the operation; no result is emitted.
- FSM states: IDLE, SUM_HI, SUM_LO, CMP, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch g_input and e_input, go to SUM_HI.
  - Otherwise stay in IDLE.
- SUM_HI:
  - Adder A=g[2N-1:N], B=e[2N-1:N], CI=0.
  - Register the N-bit sum plus carry into tmp_0 (N+1 bits).
  - Go to SUM_LO.
- SUM_LO:
  - Adder A=g[N-1:0], B=e[N-1:0], CI=0.
  - Register the result into tmp_1.
  - Go to CMP.
- CMP:
  - Unsigned (N+1)-bit compare of tmp_0 vs tmp_1; the carry bit participates.
  - Register code 0, 1 or 2 into o. Go to OUT.
- OUT:
  - out_valid=1. o is held stable until out_ready.
  - On out_valid&&out_ready: increment the matching counter, go to IDLE.
- in_ready is 0 in every state except IDLE. in_valid is ignored outside IDLE.
- Latency: accept at cycle t -> out_valid high at t+4. With out_ready held high, minimum issue interval is 5 cycles.
- Only one adder instance exists; its operand mux is selected by state. Adder inputs are don't-care outside SUM_HI/SUM_LO but must not be X.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr clears all three on the next edge.
  - cnt_clr coincident with a result handshake: clear wins and the increment is dropped.
  - cnt_clr has no effect on the FSM.
- busy = (state != IDLE).
- o retains its last code after the OUT handshake until the next CMP; consumers qualify with out_valid.

Decomposition:
- Package moda_pkg holds:
  - FSM state enum (IDLE, SUM_HI, SUM_LO, CMP, OUT).
  - Result code constants RES_GT=2'd0, RES_LT=2'd1, RES_EQ=2'd2, RES_NONE=2'd3.
- One sub-module is natural: the team's existing parameterised ADD cell, instantiated once with N=16, CI tied 0, S and CO concatenated into the sum register input.
- Compare logic and FSM stay in moda_sched.

Test Plan:
1. g=0x0001_0000, e=0x0002_0000, out_ready=1 -> tmp_0=3, tmp_1=0; o=0 with out_valid exactly 4 cycles after accept; cnt_gt=1.
2. g=0x0000_0005, e=0x0000_0001 -> tmp_0=0, tmp_1=6; o=1; cnt_lt=1.
3. Carry check: g=0xFFFF_0000, e=0x0001_FFFF -> tmp_0=0x1_0000, tmp_1=0x0_FFFF; o=0. Dropping the carry would wrongly give o=1.
4. Equal case: g=0x1234_1234, e=0 -> o=2, cnt_eq=1.
5. Backpressure: out_ready=0 for 10 cycles, then 1.
   - o and out_valid stay stable; in_ready=0 throughout.
   - A held in_valid with new operands is not accepted until the cycle after the handshake.
6. Reset and counters:
   - Assert rst low during SUM_LO -> all outputs take their reset values (o=3) immediately; no result after release.
   - With CNT_W=2, four code-0 operations -> cnt_gt=3 (saturated).
   - cnt_clr coincident with a handshake -> all counters 0.

Source files
------------

// File: rtl/moda_pkg.sv
// moda_pkg: shared types and constants for the moda half-sum compare controller.
//   state_t  - controller FSM states
//   RES_*    - 2-bit result codes driven on moda_sched.o
package moda_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUM_HI = 3'd1,
    SUM_LO = 3'd2,
    CMP    = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam logic [1:0] RES_GT   = 2'd0;  // hi-sum > lo-sum
  localparam logic [1:0] RES_LT   = 2'd1;  // hi-sum < lo-sum
  localparam logic [1:0] RES_EQ   = 2'd2;  // sums equal
  localparam logic [1:0] RES_NONE = 2'd3;  // reset value only, never computed

endpackage

// File: rtl/moda_sched_add.sv
// moda_sched_add: parameterised N-bit ripple ADD cell.
//   a, b : N-bit addends
//   ci   : carry in
//   s    : N-bit sum
//   co   : carry out
module moda_sched_add #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

endmodule

// File: rtl/moda_sched.sv
// moda_sched: sequential controller for the moda half-sum compare.
// One accepted operand pair is summed half by half on a single shared adder,
// the two (N+1)-bit sums are compared, and a 2-bit code is returned over a
// valid/ready handshake. Saturating tallies count each outcome.
//   clk                 - clock, rising edge
//   rst                 - asynchronous reset, active low
//   in_valid/in_ready   - operand handshake (g_input, e_input, 2N bits each)
//   out_valid/out_ready - result handshake (o)
//   busy                - controller not idle
//   cnt_clr             - synchronous clear of all tallies
//   cnt_gt/lt/eq        - saturating outcome tallies
module moda_sched
  import moda_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   g_input,
  input  logic [2*N-1:0]   e_input,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       o,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq
);

  state_t         state_reg, state_next;
  logic [2*N-1:0] g_reg, e_reg;
  logic [N:0]     tmp_0_reg, tmp_1_reg;
  logic [1:0]     o_reg;
  logic [N-1:0]   add_a, add_b, add_s;
  logic           add_co;
  logic [1:0]     cmp_code;
  logic           accept, deliver;
  logic [CNT_W-1:0] cnt_reg [3];

  // in_ready is gated by rst so it drops the moment reset is asserted.
  assign in_ready  = (state_reg == IDLE) && rst;
  assign out_valid = (state_reg == OUT);
  assign busy      = (state_reg != IDLE);
  assign o         = o_reg;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // Shared adder operand mux: high halves in SUM_HI, low halves otherwise.
  // The operand registers reset to zero, so the adder never sees X.
  always_comb begin
    add_a = g_reg[N-1:0];
    add_b = e_reg[N-1:0];
    if (state_reg == SUM_HI) begin
      add_a = g_reg[2*N-1:N];
      add_b = e_reg[2*N-1:N];
    end
  end

  moda_sched_add #(.N(N)) u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

  // Full (N+1)-bit compare: the carry bit must take part.
  always_comb begin
    cmp_code = RES_EQ;
    if (tmp_0_reg > tmp_1_reg)      cmp_code = RES_GT;
    else if (tmp_0_reg < tmp_1_reg) cmp_code = RES_LT;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SUM_HI;
      SUM_HI:  state_next = SUM_LO;
      SUM_LO:  state_next = CMP;
      CMP:     state_next = OUT;
      OUT:     if (deliver) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      e_reg     <= '0;
      tmp_0_reg <= '0;
      tmp_1_reg <= '0;
      o_reg     <= RES_NONE;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        g_reg <= g_input;
        e_reg <= e_input;
      end
      if (state_reg == SUM_HI) tmp_0_reg <= {add_co, add_s};
      if (state_reg == SUM_LO) tmp_1_reg <= {add_co, add_s};
      if (state_reg == CMP)    o_reg     <= cmp_code;
    end
  end

  // Tally index equals the result code (GT=0, LT=1, EQ=2). Clear beats a
  // coincident increment; counters stick at all-ones.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_clr) begin
          cnt_reg[gi] <= '0;
        end else if (deliver && (o_reg == 2'(gi)) && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign cnt_gt = cnt_reg[RES_GT];
  assign cnt_lt = cnt_reg[RES_LT];
  assign cnt_eq = cnt_reg[RES_EQ];

endmodule

// File: tb/tb_moda_sched.sv
// tb_moda_sched: directed bench for moda_sched. A second instance with
// CNT_W=2 shares all inputs so tally saturation is observable.
module tb_moda_sched;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cnt_clr;
  logic [31:0] g_input, e_input;
  logic        in_ready, out_valid, busy;
  logic [1:0]  o;
  logic [7:0]  cnt_gt, cnt_lt, cnt_eq;
  logic        in_ready2, out_valid2, busy2;
  logic [1:0]  o2;
  logic [1:0]  cnt_gt2, cnt_lt2, cnt_eq2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  moda_sched #(.N(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .g_input(g_input), .e_input(e_input), .out_valid(out_valid),
    .out_ready(out_ready), .o(o), .busy(busy), .cnt_clr(cnt_clr),
    .cnt_gt(cnt_gt), .cnt_lt(cnt_lt), .cnt_eq(cnt_eq)
  );

  moda_sched #(.N(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .g_input(g_input), .e_input(e_input), .out_valid(out_valid2),
    .out_ready(out_ready), .o(o2), .busy(busy2), .cnt_clr(cnt_clr),
    .cnt_gt(cnt_gt2), .cnt_lt(cnt_lt2), .cnt_eq(cnt_eq2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with out_ready held high; checks exact 4-cycle latency.
  task automatic run_op(input logic [31:0] g, input logic [31:0] e,
                        input logic [16:0] t0, input logic [16:0] t1,
                        input logic [1:0] code);
    g_input = g; e_input = e; in_valid = 1'b1; out_ready = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    tick();                       // accept edge
    in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    tick();
    check("tmp_0", 32'(dut.tmp_0_reg), 32'(t0));
    tick();
    check("tmp_1", 32'(dut.tmp_1_reg), 32'(t1));
    check("valid_early", 32'(out_valid), 32'd0);
    tick();
    check("valid_at_t4", 32'(out_valid), 32'd1);
    check("o_code", 32'(o), 32'(code));
    tick();                       // handshake edge
    check("valid_after_hs", 32'(out_valid), 32'd0);
    $display("op g=%08h e=%08h -> o=%0d gt=%0d lt=%0d eq=%0d", g, e, o, cnt_gt, cnt_lt, cnt_eq);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    g_input = '0; e_input = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_o", 32'(o), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnts", {8'd0, cnt_gt, cnt_lt, cnt_eq}, 32'd0);
    rst = 1'b1;
    tick();

    run_op(32'h0001_0000, 32'h0002_0000, 17'h3, 17'h0, 2'd0);
    check("cnt_gt_1", 32'(cnt_gt), 32'd1);
    run_op(32'h0000_0005, 32'h0000_0001, 17'h0, 17'h6, 2'd1);
    check("cnt_lt_1", 32'(cnt_lt), 32'd1);
    run_op(32'hFFFF_0000, 32'h0001_FFFF, 17'h1_0000, 17'h0_FFFF, 2'd0);
    check("cnt_gt_2", 32'(cnt_gt), 32'd2);
    run_op(32'h1234_1234, 32'h0000_0000, 17'h1234, 17'h1234, 2'd2);
    check("cnt_eq_1", 32'(cnt_eq), 32'd1);

    // Backpressure with a second request held on in_valid.
    g_input = 32'h0000_0001; e_input = 32'h0000_0003; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    g_input = 32'h0007_0000; e_input = 32'h0000_0000;
    tick(); tick(); tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_o", 32'(o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_o", 32'(o), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_cnt_lt", 32'(cnt_lt), 32'd2);
    tick();
    in_valid = 1'b0;
    check("bp_second_accept", 32'(busy), 32'd1);
    tick(); tick(); tick();
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_o", 32'(o), 32'd0);
    tick();
    check("bp_cnt_gt", 32'(cnt_gt), 32'd3);
    $display("backpressure done: gt=%0d lt=%0d", cnt_gt, cnt_lt);

    run_op(32'h0002_0000, 32'h0000_0000, 17'h2, 17'h0, 2'd0);
    run_op(32'h0002_0000, 32'h0000_0000, 17'h2, 17'h0, 2'd0);
    check("cnt_gt_5", 32'(cnt_gt), 32'd5);
    check("sat_gt2", 32'(cnt_gt2), 32'd3);
    check("sat_lt2", 32'(cnt_lt2), 32'd2);
    check("sat_eq2", 32'(cnt_eq2), 32'd1);

    // Clear coincident with a result handshake.
    g_input = 32'h0; e_input = 32'h0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("clr_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1; out_ready = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnts", {8'd0, cnt_gt, cnt_lt, cnt_eq}, 32'd0);
    check("clr_cnts2", {26'd0, cnt_gt2, cnt_lt2, cnt_eq2}, 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    $display("clear done: gt=%0d lt=%0d eq=%0d", cnt_gt, cnt_lt, cnt_eq);

    // Reset during SUM_LO.
    run_op(32'h0001_0000, 32'h0000_0000, 17'h1, 17'h0, 2'd0);
    g_input = 32'h0003_0000; e_input = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();                       // now in SUM_LO
    #2 rst = 1'b0;
    #1;
    check("ar_o", 32'(o), 32'd3);
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_cnt_gt", 32'(cnt_gt), 32'd0);
    tick();
    check("ar_in_ready_held", 32'(in_ready), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ar_no_result", 32'(out_valid), 32'd0);
    end
    check("ar_ready_after", 32'(in_ready), 32'd1);
    $display("async reset done: o=%0d busy=%0d", o, busy);

    run_op(32'h0000_0002, 32'h0000_0002, 17'h0, 17'h4, 2'd1);
    check("post_rst_lt", 32'(cnt_lt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
